// File: rtl/div_pkg.sv
// Shared widths and state encoding for the dividend reconstructor.
package div_pkg;
   localparam int DW    = 16;
   localparam int QW    = 8;
   localparam int CNT_W = $clog2(QW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/div_reconstruct_if.sv
// Operand/result handshake bundle for div_reconstruct.
// DIV_RECON_CHECK_EN adds the expected-dividend input and the two check flags.
interface div_reconstruct_if;
   import div_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [QW-1:0] q;
   logic [QW-1:0] y;
   logic [QW-1:0] r;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] x;
`ifdef DIV_RECON_CHECK_EN
   logic [DW-1:0] x_exp;
   logic          mismatch;
   logic          rem_err;

   modport master (output in_valid, q, y, r, out_ready, x_exp,
                   input  in_ready, out_valid, x, mismatch, rem_err);
   modport slave  (input  in_valid, q, y, r, out_ready, x_exp,
                   output in_ready, out_valid, x, mismatch, rem_err);
`else
   modport master (output in_valid, q, y, r, out_ready,
                   input  in_ready, out_valid, x);
   modport slave  (input  in_valid, q, y, r, out_ready,
                   output in_ready, out_valid, x);
`endif
endinterface

// File: rtl/div_recon_step.sv
// One shift-add multiply step; kept combinational so it can be chained for an unrolled build.
module div_recon_step
   import div_pkg::*;
(
   input  logic [DW-1:0] acc,
   input  logic [DW-1:0] mcand,
   input  logic [QW-1:0] mplier,
   output logic [DW-1:0] acc_nxt,
   output logic [DW-1:0] mcand_nxt,
   output logic [QW-1:0] mplier_nxt
);
   // Add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_nxt    = mplier[0] ? acc + mcand : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
   end
endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds a dividend x = q*y + r from exact-divider outputs using QW shift-add steps.
// Optional DIV_RECON_CHECK_EN: compares x against a supplied x_exp and flags r >= y.
//
// state | meaning
// IDLE  | ready for operands, last result stays on x
// RUN   | QW shift-add iterations, cnt counts them
// DONE  | out_valid high, x held until out_ready
module div_reconstruct
   import div_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   div_reconstruct_if.slave   bus
);
   state_t           state;
   logic [DW-1:0]    acc;
   logic [DW-1:0]    mcand;
   logic [QW-1:0]    mplier;
   logic [CNT_W-1:0] cnt;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [DW-1:0]    x_q;
   logic [DW-1:0]    acc_nxt;
   logic [DW-1:0]    mcand_nxt;
   logic [QW-1:0]    mplier_nxt;
`ifdef DIV_RECON_CHECK_EN
   logic [DW-1:0]    x_exp_q;
   logic             rem_pend;
   logic             mismatch_q;
   logic             rem_err_q;

   assign bus.mismatch = mismatch_q;
   assign bus.rem_err  = rem_err_q;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.x         = x_q;

   div_recon_step u_step (
      .acc        (acc),
      .mcand      (mcand),
      .mplier     (mplier),
      .acc_nxt    (acc_nxt),
      .mcand_nxt  (mcand_nxt),
      .mplier_nxt (mplier_nxt)
   );

   // Control FSM and datapath registers; handshake outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         x_q         <= '0;
`ifdef DIV_RECON_CHECK_EN
         x_exp_q     <= '0;
         rem_pend    <= 1'b0;
         mismatch_q  <= 1'b0;
         rem_err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  acc        <= DW'(bus.r);
                  mcand      <= DW'(bus.y);
                  mplier     <= bus.q;
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= RUN;
`ifdef DIV_RECON_CHECK_EN
                  x_exp_q    <= bus.x_exp;
                  rem_pend   <= (bus.r >= bus.y);
`endif
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand_nxt;
               mplier <= mplier_nxt;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(QW - 1)) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  x_q         <= acc_nxt;
`ifdef DIV_RECON_CHECK_EN
                  mismatch_q  <= (acc_nxt != x_exp_q);
                  rem_err_q   <= rem_pend;
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
`ifdef DIV_RECON_CHECK_EN
                  mismatch_q  <= 1'b0;
                  rem_err_q   <= 1'b0;
`endif
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
